instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Packs RV32I instruction fields (opcode, rd, func3, rs1, rs2, func7, immediate) into 32-bit instruction words and streams them, with sequential addresses, toward instruction memory. It is the encode-side counterpart of the decode stage and is used by the program loader and self-test paths to build instruction memory images in hardware. A small FIFO decouples the field-producing source from the memory writer.

## Interface
- FIFO_DEPTH, 4: encoded-word buffer entries; power of two, ≥2.
- ADDR_WIDTH, 10: word-address width.
- BASE_ADDR, 0: first word address after reset or `clear`.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: empties the FIFO and sets `addr` to BASE_ADDR.
- in_valid  in  1  field set valid.
- in_ready  out  1  equals `!full`.
- opcode  in  7  instruction[6:0].
- rd  in  5  destination register.
- func3  in  3  function-3 field.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- func7  in  7  function-7 field.
- imm  in  32  immediate, byte-offset form.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  memory writer accepts.
- instr  out  32  head-of-FIFO encoded word; 0 when empty.
- addr  out  ADDR_WIDTH  word address for `instr`.
- word_count  out  16  words emitted since reset or `clear`; saturates at 0xFFFF.

## Operation
- Input handshake is `in_valid && in_ready`. The fields are encoded combinationally and pushed into the FIFO on the same edge.
- Encoding is selected by opcode:
  - R (0110011): {func7, rs2, rs1, func3, rd, opcode}.
  - I (0010011, 0000011, 1100111, 1110011): {imm[11:0], rs1, func3, rd, opcode}.
  - Shift-immediate (0010011 with func3 001 or 101): {func7, imm[4:0], rs1, func3, rd, opcode}.
  - S (0100011): {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
  - U (0110111, 0010111): {imm[31:12], rd, opcode}.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Immediate bits that no format uses are ignored. There is no range check.
- Output handshake is `out_valid && out_ready`. It pops the FIFO head, increments `addr` (wrapping from 2^ADDR_WIDTH−1 to 0), and increments `word_count`.
- A simultaneous push and pop is allowed whenever the FIFO is not full, and occupancy is unchanged.
- When the FIFO is full, `in_ready` = 0 and no push occurs, even if a pop happens on the same cycle.
- FIFO control uses pointer wrap bits; full and empty are derived from those pointers.
- `clear` has priority over both handshakes on its cycle: any push and pop are discarded, and `word_count` is set to 0.

## Timing
- Reset values: out_valid 0, instr 0, addr BASE_ADDR, word_count 0, FIFO empty. `in_ready` = 1 during and after reset.
- Latency: a word accepted at edge N appears on `instr` with `out_valid` = 1 after edge N (registered FIFO). There is no combinational path from input to output.
- Throughput: one word per cycle while `out_ready` is held high.
- `instr` and `addr` are stable while `out_valid && !out_ready`.
- `rst` asserted mid-stream discards the FIFO contents immediately, without waiting for a clock.

## Configuration
- `ENCODER_ILLEGAL_CHECK_EN` defined:
  - Opcodes outside the list above are accepted but not pushed, so `in_ready` stays as normal.
  - Extra output `illegal`: a sticky 1-bit flag, set on the accepting edge and cleared only by `rst`/`clear`.
- Macro undefined:
  - Unknown opcodes are packed in R format and pushed.
  - The `illegal` port does not exist.

## Test plan
- add x3,x1,x2 (opcode 0x33, rd 3, rs1 1, rs2 2, func3 0, func7 0) → instr 0x002081B3 at addr 0, one cycle after acceptance.
- addi x1,x0,5 then sw x2,8(x1) back-to-back, out_ready = 1 → 0x00500093 @0, then 0x0020A423 @1, on consecutive cycles.
- beq x1,x2,-4; jal x1,2048; lui x5,0x12345 → 0xFE208EE3, 0x001000EF, 0x123452B7.
- out_ready = 0, push 5 words with FIFO_DEPTH = 4 → in_ready falls after the 4th, the 5th is held. Release out_ready → words drain in order; addr runs 0..4 and word_count ends at 5.
- ADDR_WIDTH = 2, emit 5 words → addr sequence 0,1,2,3,0. Assert clear with 2 words queued → out_valid 0 next cycle, addr 0, word_count 0.
- With the macro defined, opcode 0x7F → nothing pushed, illegal = 1 until clear. Without it → R-packed word emitted.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// Field-producer / memory-writer bus of instruction_encoder.
// Optional `illegal` flag exists only when ENCODER_ILLEGAL_CHECK_EN is defined.
interface instruction_encoder_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  clear;
   logic                  in_valid;
   logic                  in_ready;
   logic [6:0]            opcode;
   logic [4:0]            rd;
   logic [2:0]            func3;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [6:0]            func7;
   logic [31:0]           imm;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           instr;
   logic [ADDR_WIDTH-1:0] addr;
   logic [15:0]           word_count;
`ifdef ENCODER_ILLEGAL_CHECK_EN
   logic                  illegal;
`endif

   modport master (
      output clear, in_valid, opcode, rd, func3, rs1, rs2, func7, imm, out_ready,
      input  in_ready, out_valid, instr, addr, word_count
`ifdef ENCODER_ILLEGAL_CHECK_EN
      , input illegal
`endif
   );

   modport slave (
      input  clear, in_valid, opcode, rd, func3, rs1, rs2, func7, imm, out_ready,
      output in_ready, out_valid, instr, addr, word_count
`ifdef ENCODER_ILLEGAL_CHECK_EN
      , output illegal
`endif
   );
endinterface

// File: rtl/instruction_encoder.sv
// RV32I field packer feeding a small FIFO that streams words with sequential addresses.
// Optional feature macro: ENCODER_ILLEGAL_CHECK_EN (drop unknown opcodes, sticky `illegal` flag).
module instruction_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0
) (
   input logic                  clk,
   input logic                  rst,
   instruction_encoder_if.slave enc
);
   localparam int                    PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_RST = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_SHIFT, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
   } fmt_e;

   fmt_e        w_fmt;
   logic [31:0] w_word;
   logic        w_legal;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_fmt = FMT_BAD;
      case (enc.opcode)
         7'b0110011: w_fmt = FMT_R;
         7'b0010011: begin
            if (enc.func3 == 3'b001 || enc.func3 == 3'b101) w_fmt = FMT_SHIFT;
            else                                            w_fmt = FMT_I;
         end
         7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
         7'b0100011: w_fmt = FMT_S;
         7'b1100011: w_fmt = FMT_B;
         7'b0110111, 7'b0010111: w_fmt = FMT_U;
         7'b1101111: w_fmt = FMT_J;
         default:    w_fmt = FMT_BAD;
      endcase
   end

   // Unknown opcodes fall through to R packing.
   always_comb begin
      w_word = {enc.func7, enc.rs2, enc.rs1, enc.func3, enc.rd, enc.opcode};
      case (w_fmt)
         FMT_I:     w_word = {enc.imm[11:0], enc.rs1, enc.func3, enc.rd, enc.opcode};
         FMT_SHIFT: w_word = {enc.func7, enc.imm[4:0], enc.rs1, enc.func3, enc.rd, enc.opcode};
         FMT_S:     w_word = {enc.imm[11:5], enc.rs2, enc.rs1, enc.func3, enc.imm[4:0], enc.opcode};
         FMT_B:     w_word = {enc.imm[12], enc.imm[10:5], enc.rs2, enc.rs1, enc.func3,
                              enc.imm[4:1], enc.imm[11], enc.opcode};
         FMT_U:     w_word = {enc.imm[31:12], enc.rd, enc.opcode};
         FMT_J:     w_word = {enc.imm[20], enc.imm[10:1], enc.imm[11], enc.imm[19:12],
                              enc.rd, enc.opcode};
         default:   w_word = {enc.func7, enc.rs2, enc.rs1, enc.func3, enc.rd, enc.opcode};
      endcase
   end

`ifdef ENCODER_ILLEGAL_CHECK_EN
   assign w_legal = (w_fmt != FMT_BAD);
`else
   assign w_legal = 1'b1;
`endif

   logic [PTR_W:0] r_wr_ptr;
   logic [PTR_W:0] r_rd_ptr;
   logic [31:0]    r_mem [FIFO_DEPTH];
   logic           w_full;
   logic           w_empty;
   logic           w_in_hs;
   logic           w_push;
   logic           w_pop;

   // The extra pointer bit distinguishes full from empty when the indices match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_in_hs = enc.in_valid && !w_full;
   assign w_push  = w_in_hs && w_legal && !enc.clear;
   assign w_pop   = !w_empty && enc.out_ready && !enc.clear;

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_word;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (enc.clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
   end

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [15:0]           r_word_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr       <= ADDR_RST;
         r_word_count <= '0;
      end else if (enc.clear) begin
         r_addr       <= ADDR_RST;
         r_word_count <= '0;
      end else if (w_pop) begin
         r_addr <= r_addr + ADDR_WIDTH'(1);
         if (r_word_count != 16'hFFFF) r_word_count <= r_word_count + 16'd1;
      end
   end

`ifdef ENCODER_ILLEGAL_CHECK_EN
   logic r_illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              r_illegal <= 1'b0;
      else if (enc.clear)                   r_illegal <= 1'b0;
      else if (w_in_hs && !w_legal)         r_illegal <= 1'b1;
   end

   assign enc.illegal = r_illegal;
`endif

   assign enc.in_ready   = !w_full;
   assign enc.out_valid  = !w_empty;
   assign enc.instr      = w_empty ? 32'd0 : r_mem[r_rd_ptr[PTR_W-1:0]];
   assign enc.addr       = r_addr;
   assign enc.word_count = r_word_count;
endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: queue-based reference model, negedge monitor.
// Covers known-answer encodings, back-pressure, clear, async reset, address wrap, random traffic.
module tb_instruction_encoder;
   localparam int DEPTH = 4;
   localparam int AW    = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instruction_encoder_if #(.ADDR_WIDTH(AW)) bus ();

   instruction_encoder #(
      .FIFO_DEPTH(DEPTH),
      .ADDR_WIDTH(AW),
      .BASE_ADDR (0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enc(bus)
   );

   typedef struct {
      logic [31:0] instr;
      bit          kat_en;
      logic [31:0] kat;
   } exp_t;

   exp_t exp_q[$];
   int   m_addr;
   int   m_count;
   bit   m_illegal;
   bit   mdl_accepted;
   int   m_occ;
   int   m_kind;
   bit   cur_kat_en;
   logic [31:0] cur_kat;
   int   rdy_mode;
   bit   mon_en;
   int   n_checks;
   int   n_pass;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
   endtask

   // Format class from the opcode table: 0 R, 1 I, 2 shift, 3 S, 4 B, 5 U, 6 J, -1 unknown.
   function automatic int fmt_kind(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         7'h33: return 0;
         7'h13: return (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
         7'h03, 7'h67, 7'h73: return 1;
         7'h23: return 3;
         7'h63: return 4;
         7'h37, 7'h17: return 5;
         7'h6F: return 6;
         default: return -1;
      endcase
   endfunction

   // Field placement expressed with shifts and masks on plain 32-bit numbers.
   function automatic logic [31:0] ref_encode(input int kind, input logic [6:0] op,
         input logic [4:0] rd_f, input logic [2:0] f3, input logic [4:0] rs1_f,
         input logic [4:0] rs2_f, input logic [6:0] f7, input logic [31:0] u);
      logic [31:0] o, d, c3, s1, s2, c7;
      o  = 32'(op);
      d  = 32'(rd_f) << 7;
      c3 = 32'(f3) << 12;
      s1 = 32'(rs1_f) << 15;
      s2 = 32'(rs2_f) << 20;
      c7 = 32'(f7) << 25;
      case (kind)
         1: return o | d | c3 | s1 | ((u & 32'hFFF) << 20);
         2: return o | d | c3 | s1 | ((u & 32'h1F) << 20) | c7;
         3: return o | ((u & 32'h1F) << 7) | c3 | s1 | s2 | (((u >> 5) & 32'h7F) << 25);
         4: return o | (((u >> 11) & 1) << 7) | (((u >> 1) & 32'hF) << 8) | c3 | s1 | s2 |
                   (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 1) << 31);
         5: return o | d | (u & 32'hFFFFF000);
         6: return o | d | (u & 32'h000FF000) | (((u >> 11) & 1) << 20) |
                   (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 1) << 31);
         default: return o | d | c3 | s1 | s2 | c7;
      endcase
   endfunction

   // Reference model: updates its view of the FIFO on each edge from the driven inputs only.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_addr       = 0;
         m_count      = 0;
         m_illegal    = 1'b0;
         mdl_accepted = 1'b0;
      end else begin
         m_occ        = exp_q.size();
         mdl_accepted = 1'b0;
         if (bus.clear) begin
            exp_q.delete();
            m_addr    = 0;
            m_count   = 0;
            m_illegal = 1'b0;
         end else begin
            if (m_occ > 0 && bus.out_ready) begin
               void'(exp_q.pop_front());
               m_addr = (m_addr + 1) % (1 << AW);
               if (m_count < 65535) m_count++;
            end
            if (bus.in_valid && m_occ < DEPTH) begin
               mdl_accepted = 1'b1;
               m_kind = fmt_kind(bus.opcode, bus.func3);
`ifdef ENCODER_ILLEGAL_CHECK_EN
               if (m_kind < 0) m_illegal = 1'b1;
               else
`endif
               exp_q.push_back('{ref_encode(m_kind, bus.opcode, bus.rd, bus.func3, bus.rs1,
                                            bus.rs2, bus.func7, bus.imm), cur_kat_en, cur_kat});
            end
         end
      end
   end

   // Monitor: compares every visible output against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && mon_en) begin
         check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
         check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
         check("addr", 32'(bus.addr), 32'(m_addr));
         check("word_count", 32'(bus.word_count), 32'(m_count));
`ifdef ENCODER_ILLEGAL_CHECK_EN
         check("illegal", 32'(bus.illegal), 32'(m_illegal));
`endif
         if (exp_q.size() != 0) begin
            check("instr", bus.instr, exp_q[0].instr);
            if (exp_q[0].kat_en) check("instr_known_answer", bus.instr, exp_q[0].kat);
         end else begin
            check("instr_empty", bus.instr, 32'd0);
         end
      end
   end

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'b1;
         default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [6:0] op, input logic [4:0] rd_f, input logic [2:0] f3,
         input logic [4:0] rs1_f, input logic [4:0] rs2_f, input logic [6:0] f7,
         input logic [31:0] im);
      bus.opcode = op;  bus.rd  = rd_f;  bus.func3 = f3;
      bus.rs1    = rs1_f; bus.rs2 = rs2_f; bus.func7 = f7;
      bus.imm    = im;
   endtask

   task automatic wait_accept(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (mdl_accepted) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail(name);
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd_f, input logic [2:0] f3,
         input logic [4:0] rs1_f, input logic [4:0] rs2_f, input logic [6:0] f7,
         input logic [31:0] im, input bit kat_en, input logic [31:0] kat);
      set_fields(op, rd_f, f3, rs1_f, rs2_f, f7, im);
      cur_kat_en   = kat_en;
      cur_kat      = kat;
      bus.in_valid = 1'b1;
      wait_accept("send_accept");
      bus.in_valid = 1'b0;
      cur_kat_en   = 1'b0;
   endtask

   task automatic send_random();
      send(7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
           7'($urandom), $urandom, 1'b0, 32'd0);
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      step();
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
   endtask

   function automatic logic [6:0] rand_opcode();
      logic [6:0] ops [10];
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      if ($urandom_range(0, 9) == 0) return 7'($urandom);
      return ops[$urandom_range(0, 9)];
   endfunction

   task automatic random_phase(input int cycles, input bit with_clear);
      for (int i = 0; i < cycles; i++) begin
         set_fields(rand_opcode(), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                    7'($urandom), $urandom);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.clear    = with_clear && ($urandom_range(0, 24) == 0);
         step();
      end
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;  n_pass = 0;  mon_en = 1'b0;  rdy_mode = 0;
      cur_kat_en = 1'b0;  cur_kat = '0;
      bus.clear = 1'b0;  bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
      set_fields('0, '0, '0, '0, '0, '0, '0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_instr", bus.instr, 32'd0);
      check("rst_addr", 32'(bus.addr), 32'd0);
      check("rst_word_count", 32'(bus.word_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // Known-answer encodings, streamed with out_ready held high.
      rdy_mode = 1;
      step();
      send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b1, 32'h002081B3);
      drain();
      send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
      send(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
      send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
      send(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b1, 32'h001000EF);
      send(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
      send(7'h7F, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b1, 32'h002081FF);
      drain();
      pulse_clear();

      // Back-pressure: four fill the FIFO, the fifth waits until the writer drains.
      rdy_mode = 0;
      step();
      for (int i = 0; i < 4; i++) send_random();
      set_fields(7'h13, 5'd7, 3'd0, 5'd6, 5'd0, 7'd0, 32'd42);
      bus.in_valid = 1'b1;
      repeat (3) step();
      rdy_mode = 1;
      wait_accept("fifth_accept");
      bus.in_valid = 1'b0;
      drain();
      @(negedge clk);
      check("fill_word_count", 32'(bus.word_count), 32'd5);
      check("fill_addr", 32'(bus.addr), 32'd5);
      step();

      // Clear with two queued, colliding with a push and a pop.
      rdy_mode = 0;
      step();
      send_random();
      send_random();
      rdy_mode = 1;
      set_fields(7'h33, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd0);
      bus.in_valid = 1'b1;
      bus.clear    = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      rdy_mode     = 0;
      @(negedge clk);
      check("clear_out_valid", 32'(bus.out_valid), 32'd0);
      check("clear_addr", 32'(bus.addr), 32'd0);
      check("clear_word_count", 32'(bus.word_count), 32'd0);
      step();

      // Asynchronous reset mid-stream empties the FIFO without a clock edge.
      rdy_mode = 1;
      send_random();
      send_random();
      rdy_mode = 0;
      send_random();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_instr", bus.instr, 32'd0);
      check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("async_rst_word_count", 32'(bus.word_count), 32'd0);
      step();
      rst = 1'b0;
      step();

      // Long random stream carries addr past 2^AW-1; then a shorter run with clears.
      rdy_mode = 2;
      random_phase(3000, 1'b0);
      random_phase(600, 1'b1);
      rdy_mode = 1;
      drain();
      repeat (2) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
